if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage of the 16-bit MIPS pipeline, sitting directly upstream of the IF/ID register. It owns the PC and issues requests on a request/acknowledge instruction-memory port. On each accepted word it presents `instr` and `pc_plus2` with a one-cycle write strobe for IF/ID. It absorbs hazard stalls with a one-entry hold buffer and squashes wrong-path fetches on a redirect by injecting a NOP.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset; bit 0 must be 0.
- `NOP_INSTR`, default 16'h0000: encoding written to IF/ID on a squash.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: fetch request; held high with stable `imem_addr` until `imem_ack`.
- `imem_addr` out 16: byte address of the requested halfword.
- `imem_ack` in 1: memory returns `imem_rdata` this cycle; may be asserted in the same cycle `imem_req` first rises (zero-wait).
- `imem_rdata` in 16: instruction word, valid when `imem_ack`.
- `stall` in 1: hazard unit requests that IF/ID not be written.
- `redirect` in 1: taken branch or jump resolved downstream.
- `redirect_pc` in 16: target; bit 0 forced to 0.
- `ifid_wr` out 1: drives IF/ID `ifid_en`.
- `instr` out 16: to IF/ID `instr`.
- `pc_plus2` out 16: to IF/ID `pc_plus2in`.

## Operation
- Registers: `pc` (16), `buf_instr` and `buf_pc2` (16 each), `drop_addr` (16), state ∈ {RUN, HOLD, DROP}.
- Priority within a cycle: `rst` > `redirect` > `stall`.
- Reset: `pc`=RESET_PC, state=RUN, buffers=0. While `rst`=1: `imem_req`=0, `imem_addr`=RESET_PC, `ifid_wr`=0, `instr`=0, `pc_plus2`=0.
- RUN: `imem_req`=1, `imem_addr`=`pc`.
  - ack && !stall && !redirect: `ifid_wr`=1, `instr`=`imem_rdata`, `pc_plus2`=`pc`+2; `pc` <= `pc`+2.
  - ack && stall && !redirect: `ifid_wr`=0; buffer <= {`imem_rdata`, `pc`+2}; `pc` <= `pc`+2; go to HOLD.
  - !ack && stall: keep requesting; `ifid_wr`=0.
- HOLD: `imem_req`=0. `instr`/`pc_plus2` come from the buffer.
  - !stall: `ifid_wr`=1; go to RUN.
  - stall: `ifid_wr`=0; stay in HOLD.
- DROP: `imem_req`=1, `imem_addr`=`drop_addr`, `ifid_wr`=0 (unless a redirect occurs). On ack, discard the data and go to RUN.
- Redirect, in any state:
  - `ifid_wr`=1, `instr`=NOP_INSTR, `pc_plus2`=0.
  - `pc` <= {`redirect_pc`[15:1], 1'b0}.
  - Buffer contents are discarded.
  - Next state:
    - RUN without ack that cycle: DROP, with `drop_addr` <= `pc`.
    - DROP without ack: stay in DROP.
    - Otherwise: RUN.
  - The NOP is written even when `stall`=1.
- Arithmetic: `pc`+2 is modulo 2^16 (16'hFFFE -> 16'h0000). No carry out.
- When `ifid_wr`=0, `instr`/`pc_plus2` are don't-care; drive the last presented values.

## Timing
- Zero-wait memory: one instruction per cycle. The instruction fetched at `pc`=A appears in the same cycle as its ack, with `pc_plus2`=A+2. IF/ID captures it at the next edge.
- N-wait memory: N extra cycles per instruction, with `ifid_wr`=0 during the wait.
- Stall release from HOLD: the buffered word is written on the first cycle `stall`=0. The next request issues one cycle later, so there is a 1-cycle bubble.
- Redirect penalty: the NOP is written in the redirect cycle. The target is requested the next cycle, or after the dropped ack if the state is DROP.
- `imem_addr` never changes while `imem_req`=1 and no ack has been seen.
- Reset mid-request: the request drops immediately. The memory must tolerate the abandoned request.

## Structure
- `mips_pkg` holds:
  - `INSTR_W`=16
  - `NOP_INSTR` default
  - fetch state enum `if_state_t` {RUN, HOLD, DROP}
- One sub-module, `fetch_hold_buf`: a 1-entry register pair for {`instr`, `pc_plus2`} with load/clear. Next-state logic and the PC stay in `if_fetch`.

## Test plan
- Reset with RESET_PC=16'h0040, zero-wait memory returning addr^16'hA5A5 -> `imem_addr` sequence 0040, 0042, 0044. `ifid_wr`=1 each cycle from the first post-reset cycle, with `pc_plus2`=0042, 0044, 0046.
- Ack on the fetch of 0x0010 while `stall`=1 for 3 cycles -> `ifid_wr`=0 for 3 cycles and `imem_req`=0 while in HOLD. Then one write with `instr`=word@0010, `pc_plus2`=0012, followed by a request for 0012.
- 2-wait memory; redirect to 16'h0101 one cycle after the request for 0x0020 -> NOP written that cycle. `imem_addr` stays 0020 until its ack, and that data is never written. The next request is for 0100.
- Redirect and ack in the same cycle with `stall`=1 -> `ifid_wr`=1 with NOP_INSTR, no HOLD entry, and the next request is the target.
- PC=16'hFFFE with zero-wait memory -> `pc_plus2`=0000 and the next request is for 0000.
- Assert `rst` while in DROP and in HOLD -> the next cycle shows the reset output values, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the 16-bit MIPS pipeline front end: datapath width,
// default NOP encoding, fetch FSM states and small PC arithmetic helpers.
package mips_pkg;

  localparam int INSTR_W = 16;

  // Encoding injected into IF/ID when a wrong-path fetch is squashed.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  // RUN : requesting the word at pc
  // HOLD: a fetched word is parked while the hazard unit stalls IF/ID
  // DROP: an abandoned wrong-path request is still outstanding on the bus
  typedef enum logic [1:0] {
    RUN  = 2'b00,
    HOLD = 2'b01,
    DROP = 2'b10
  } if_state_t;

  // Sequential next PC; wraps modulo 2^16 with no carry out.
  function automatic logic [INSTR_W-1:0] pc_next(input logic [INSTR_W-1:0] pc);
    return pc + 16'd2;
  endfunction

  // Instruction addresses are halfword aligned, so bit 0 is always cleared.
  function automatic logic [INSTR_W-1:0] hw_align(input logic [INSTR_W-1:0] addr);
    return {addr[INSTR_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry parking register for a fetched {instr, pc_plus2} pair that
// arrived while IF/ID was stalled. Clear wins over load.
module fetch_hold_buf
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               clr_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [INSTR_W-1:0] pc2_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [INSTR_W-1:0] pc2_o
);

  logic [INSTR_W-1:0] instr_q;
  logic [INSTR_W-1:0] pc2_q;

  // Capture a stalled word on load; reset or clear empties the entry.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      instr_q <= 16'h0000;
      pc2_q   <= 16'h0000;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc2_q   <= pc2_i;
    end else begin
      instr_q <= instr_q;
      pc2_q   <= pc2_q;
    end
  end

  assign instr_o = instr_q;
  assign pc2_o   = pc2_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the req/ack instruction
// memory port and writes IF/ID. Stalls park one word in a hold buffer;
// redirects write a NOP and let any in-flight wrong-path request finish
// unobserved (DROP) so the memory address never changes mid-request.
// The IF/ID-facing outputs are combinational so a zero-wait memory
// delivers one instruction per cycle.
module if_fetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        ifid_wr,
  output logic [15:0] instr,
  output logic [15:0] pc_plus2
);
  import mips_pkg::*;

  if_state_t          state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] drop_addr_q, drop_addr_d;
  logic [INSTR_W-1:0] last_instr_q, last_instr_d;
  logic [INSTR_W-1:0] last_pc2_q, last_pc2_d;

  logic [INSTR_W-1:0] pc_inc_s;
  logic [INSTR_W-1:0] target_s;
  logic               buf_load_s;
  logic               buf_clr_s;
  logic [INSTR_W-1:0] buf_instr_s;
  logic [INSTR_W-1:0] buf_pc2_s;

  fetch_hold_buf u_hold (
    .clk     (clk),
    .rst     (rst),
    .load_i  (buf_load_s),
    .clr_i   (buf_clr_s),
    .instr_i (imem_rdata),
    .pc2_i   (pc_inc_s),
    .instr_o (buf_instr_s),
    .pc2_o   (buf_pc2_s)
  );

  // Fetch FSM: memory port, IF/ID write strobe/data and next-state values.
  always_comb begin
    pc_inc_s    = pc_next(pc_q);
    target_s    = hw_align(redirect_pc);

    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    buf_load_s  = 1'b0;
    buf_clr_s   = 1'b0;
    imem_req    = 1'b0;
    imem_addr   = pc_q;
    ifid_wr     = 1'b0;
    instr       = last_instr_q;
    pc_plus2    = last_pc2_q;

    if (rst) begin
      // Abandon any request at once and present quiet IF/ID values.
      imem_addr   = RESET_PC;
      instr       = 16'h0000;
      pc_plus2    = 16'h0000;
      state_d     = RUN;
      pc_d        = RESET_PC;
      drop_addr_d = 16'h0000;
      buf_clr_s   = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          imem_req  = 1'b1;
          imem_addr = pc_q;
          if (redirect) begin
            // Request at pc stays on the bus until acked; its data is junk.
            ifid_wr   = 1'b1;
            instr     = NOP_INSTR;
            pc_plus2  = 16'h0000;
            pc_d      = target_s;
            buf_clr_s = 1'b1;
            if (imem_ack) begin
              state_d = RUN;
            end else begin
              state_d     = DROP;
              drop_addr_d = pc_q;
            end
          end else if (imem_ack && !stall) begin
            ifid_wr  = 1'b1;
            instr    = imem_rdata;
            pc_plus2 = pc_inc_s;
            pc_d     = pc_inc_s;
          end else if (imem_ack) begin
            // Word arrived during a stall: park it and stop requesting.
            buf_load_s = 1'b1;
            pc_d       = pc_inc_s;
            state_d    = HOLD;
          end else begin
            state_d = RUN;
          end
        end

        HOLD: begin
          instr    = buf_instr_s;
          pc_plus2 = buf_pc2_s;
          if (redirect) begin
            ifid_wr   = 1'b1;
            instr     = NOP_INSTR;
            pc_plus2  = 16'h0000;
            pc_d      = target_s;
            buf_clr_s = 1'b1;
            state_d   = RUN;
          end else if (!stall) begin
            // Release the parked word; next request issues a cycle later.
            ifid_wr = 1'b1;
            state_d = RUN;
          end else begin
            state_d = HOLD;
          end
        end

        DROP: begin
          imem_req  = 1'b1;
          imem_addr = drop_addr_q;
          if (redirect) begin
            ifid_wr   = 1'b1;
            instr     = NOP_INSTR;
            pc_plus2  = 16'h0000;
            pc_d      = target_s;
            buf_clr_s = 1'b1;
            state_d   = imem_ack ? RUN : DROP;
          end else if (imem_ack) begin
            state_d = RUN;
          end else begin
            state_d = DROP;
          end
        end

        default: begin
          state_d   = RUN;
          pc_d      = RESET_PC;
          buf_clr_s = 1'b1;
        end
      endcase
    end

    // Remember whatever was last offered to IF/ID for the idle cycles.
    if (ifid_wr) begin
      last_instr_d = instr;
      last_pc2_d   = pc_plus2;
    end else begin
      last_instr_d = last_instr_q;
      last_pc2_d   = last_pc2_q;
    end
  end

  // State, PC and presented-value registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      drop_addr_q  <= 16'h0000;
      last_instr_q <= 16'h0000;
      last_pc2_q   <= 16'h0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_addr_q  <= drop_addr_d;
      last_instr_q <= last_instr_d;
      last_pc2_q   <= last_pc2_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios followed by random
// stall/redirect/reset traffic against a variable-latency memory, all
// checked every cycle against a transaction-level reference model.
module tb_if_fetch;
  import mips_pkg::*;

  localparam logic [15:0] RST_PC = 16'h0040;
  localparam logic [15:0] NOP    = 16'h7E00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        ifid_wr;
  logic [15:0] instr;
  logic [15:0] pc_plus2;

  if_fetch #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ifid_wr     (ifid_wr),
    .instr       (instr),
    .pc_plus2    (pc_plus2)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the fetch address, the words parked during a stall,
  // and a pending wrong-path request whose reply must be thrown away.
  typedef struct { logic [15:0] ins; logic [15:0] pc2; } word_t;
  word_t       m_held[$];
  logic [15:0] m_pc = RST_PC;
  bit          m_wrong = 1'b0;
  logic [15:0] m_wrong_addr = 16'h0000;

  // Memory model: acks after cur_wait cycles of an asserted request.
  int wait_cnt  = 0;
  int cur_wait  = 0;
  int mem_wait  = 0;
  bit rand_wait = 1'b0;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_check();
    logic        e_req, e_wr, show;
    logic [15:0] e_addr, e_ins, e_pc2, word, nxt;
    if (rst) begin
      check_eq("rst_req", {15'd0, imem_req}, 16'h0000);
      check_eq("rst_addr", imem_addr, RST_PC);
      check_eq("rst_wr", {15'd0, ifid_wr}, 16'h0000);
      check_eq("rst_instr", instr, 16'h0000);
      check_eq("rst_pc2", pc_plus2, 16'h0000);
      m_pc = RST_PC;
      m_held.delete();
      m_wrong = 1'b0;
    end else begin
      e_req  = (m_held.size() == 0);
      e_addr = m_wrong ? m_wrong_addr : m_pc;
      e_wr   = 1'b0;
      e_ins  = 16'h0000;
      e_pc2  = 16'h0000;
      show   = 1'b0;
      if (redirect) begin
        e_wr = 1'b1; e_ins = NOP; e_pc2 = 16'h0000; show = 1'b1;
        if (e_req && !imem_ack) begin
          m_wrong = 1'b1; m_wrong_addr = e_addr;
        end else begin
          m_wrong = 1'b0;
        end
        m_held.delete();
        m_pc = redirect_pc & 16'hFFFE;
      end else if (m_held.size() != 0) begin
        e_ins = m_held[0].ins; e_pc2 = m_held[0].pc2; show = 1'b1;
        if (!stall) begin
          e_wr = 1'b1;
          void'(m_held.pop_front());
        end
      end else if (imem_ack) begin
        if (m_wrong) begin
          m_wrong = 1'b0;
        end else begin
          word = m_pc ^ 16'hA5A5;
          nxt  = m_pc + 16'd2;
          if (!stall) begin
            e_wr = 1'b1; e_ins = word; e_pc2 = nxt; show = 1'b1;
          end else begin
            m_held.push_back('{word, nxt});
          end
          m_pc = nxt;
        end
      end
      check_eq("req", {15'd0, imem_req}, {15'd0, e_req});
      if (e_req) check_eq("addr", imem_addr, e_addr);
      check_eq("wr", {15'd0, ifid_wr}, {15'd0, e_wr});
      if (show) begin
        check_eq("instr", instr, e_ins);
        check_eq("pc_plus2", pc_plus2, e_pc2);
      end
    end
  endtask

  // One clock: drive controls, answer the memory, then check and advance.
  task automatic cycle(input bit r, input bit s, input bit rd, input logic [15:0] rpc);
    @(posedge clk);
    #1;
    rst = r; stall = s; redirect = rd; redirect_pc = rpc;
    #1;
    if (imem_req && wait_cnt >= cur_wait) begin
      imem_ack   = 1'b1;
      imem_rdata = imem_addr ^ 16'hA5A5;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 16'($urandom);
    end
    #1;
    model_check();
    if (imem_req && imem_ack) begin
      wait_cnt = 0;
      cur_wait = rand_wait ? int'($urandom_range(0, 2)) : mem_wait;
    end else if (imem_req) begin
      wait_cnt++;
    end else begin
      wait_cnt = 0;
    end
  endtask

  initial begin
    // Reset, then zero-wait streaming from RESET_PC.
    cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 16'h0000);

    // Word at 0x0010 acked under a 3-cycle stall, then released.
    cycle(1'b0, 1'b0, 1'b1, 16'h0010);
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 16'h0000);

    // 2-wait memory, redirect to 0x0101 while 0x0020 is outstanding.
    mem_wait = 2;
    cycle(1'b0, 1'b0, 1'b1, 16'h0020);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b0, 1'b1, 16'h0101);
    repeat (5) cycle(1'b0, 1'b0, 1'b0, 16'h0000);

    // Redirect coinciding with ack and stall.
    mem_wait = 0;
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b1, 1'b1, 16'h0200);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 16'h0000);

    // PC wrap from 0xFFFE.
    cycle(1'b0, 1'b0, 1'b1, 16'hFFFE);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 16'h0000);

    // Reset while in DROP.
    mem_wait = 2;
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b0, 1'b1, 16'h0300);
    cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    mem_wait = 0;
    repeat (5) cycle(1'b0, 1'b0, 1'b0, 16'h0000);

    // Reset while in HOLD.
    cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    cycle(1'b1, 1'b1, 1'b0, 16'h0000);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 16'h0000);

    // Random traffic with 0..2 wait states per request.
    rand_wait = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 199) < 1,
            $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 8,
            16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
